// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n (LSB first) is the code for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,  // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,  // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment code.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// 4-digit seven-segment scanner; new values pass through a one-entry pending
// slot and are committed only at frame boundaries so digits never mix.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIV      = 100000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_dp,
  output logic        upd_ready,
  output logic [1:0]  digit_sel,
  output logic [6:0]  seg_n,
  output logic        dp_n
);

  // Keep at least one counter bit so DIV = 1 still elaborates.
  localparam int unsigned     CntW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  digit_idx_t      digit_q, digit_d;
  logic            tick;
  logic            frame_end;

  logic [15:0] pend_data_q;
  logic [3:0]  pend_dp_q;
  logic        pend_full_q;
  logic [15:0] disp_data_q;
  logic [3:0]  disp_dp_q;
  logic        accept;
  logic        commit;

  logic [3:0] blank;
  logic [3:0] nibble;
  logic [6:0] hex_seg_n;

  // Prescaler and digit index
  always_comb begin
    tick      = (cnt_q == CntMax);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    digit_d   = tick ? digit_q + 2'd1 : digit_q;
    frame_end = tick && (digit_q == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      digit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  // Handshake and commit; accept only happens with the slot empty, so the
  // two updates are mutually exclusive.
  always_comb begin
    accept = upd_valid && !pend_full_q;
    commit = frame_end && pend_full_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
    end else if (commit) begin
      disp_data_q <= pend_data_q;
      disp_dp_q   <= pend_dp_q;
      pend_full_q <= 1'b0;
    end else if (accept) begin
      pend_data_q <= upd_data;
      pend_dp_q   <= upd_dp;
      pend_full_q <= 1'b1;
    end
  end

  assign upd_ready = !pend_full_q;
  assign digit_sel = digit_q;

  // A digit blanks when it and every digit above it are zero; digit 0 never does.
  always_comb begin
    blank = '0;
    if (BLANK_LZ) begin
      blank[3] = (disp_data_q[15:12] == 4'h0);
      blank[2] = blank[3] && (disp_data_q[11:8] == 4'h0);
      blank[1] = blank[2] && (disp_data_q[7:4] == 4'h0);
    end
  end

  assign nibble = disp_data_q[{digit_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg_n  (hex_seg_n)
  );

  always_comb begin
    seg_n = blank[digit_q] ? SEG_BLANK : hex_seg_n;
    dp_n  = ~disp_dp_q[digit_q];
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// time-based reference model of the display and pending slot.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_data = '0;
  logic [3:0]  upd_dp = '0;

  logic       ready_a, ready_b, ready_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_data(upd_data), .upd_dp(upd_dp),
    .upd_ready(ready_a), .digit_sel(sel_a), .seg_n(seg_a), .dp_n(dp_a)
  );

  seg_scan_driver #(.DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_data(upd_data), .upd_dp(upd_dp),
    .upd_ready(ready_b), .digit_sel(sel_b), .seg_n(seg_b), .dp_n(dp_b)
  );

  seg_scan_driver #(.DIV(1), .BLANK_LZ(1'b1)) dut_c (
    .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_data(upd_data), .upd_dp(upd_dp),
    .upd_ready(ready_c), .digit_sel(sel_c), .seg_n(seg_c), .dp_n(dp_c)
  );

  // Reference model for the DIV = 4 instances: time since reset decides the
  // digit, and every 16th cycle is a frame boundary.
  int          m_t;
  logic        m_full;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pdp, m_ddp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t    <= 0;
      m_full <= 1'b0;
      m_disp <= '0;
      m_ddp  <= '0;
      m_pend <= '0;
      m_pdp  <= '0;
    end else begin
      m_t <= m_t + 1;
      if ((m_t % 16) == 15 && m_full) begin
        m_disp <= m_pend;
        m_ddp  <= m_pdp;
        m_full <= 1'b0;
      end else if (upd_valid && !m_full) begin
        m_pend <= upd_data;
        m_pdp  <= upd_dp;
        m_full <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input bit blz);
    logic [15:0] upper;
    upper = v >> (4 * d);
    if (blz && d != 0 && upper == 16'h0) return 7'h7F;
    return hex7(upper[3:0]);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle offer; caller makes sure the slot is free.
  task automatic offer(input logic [15:0] d, input logic [3:0] p);
    upd_data  = d;
    upd_dp    = p;
    upd_valid = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic wait_ready(input int bound, output int k);
    k = 0;
    while (!ready_a && k < bound) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    int k;
    offer(16'h8888, 4'hF);
    wait_ready(40, k);
    step(5);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({sel_a, seg_a, dp_a, ready_a} !== {2'd0, 7'h40, 1'b1, 1'b1})
      $display("FAIL reset_a: got sel=%0d seg=%h dp=%b rdy=%b want 0 40 1 1",
               sel_a, seg_a, dp_a, ready_a);
    else n_pass++;
    n_total++;
    if ({sel_b, seg_b, dp_b, ready_b} !== {2'd0, 7'h40, 1'b1, 1'b1})
      $display("FAIL reset_b: got sel=%0d seg=%h dp=%b rdy=%b want 0 40 1 1",
               sel_b, seg_b, dp_b, ready_b);
    else n_pass++;
    n_total++;
    if ({sel_c, seg_c, dp_c, ready_c} !== {2'd0, 7'h40, 1'b1, 1'b1})
      $display("FAIL reset_c: got sel=%0d seg=%h dp=%b rdy=%b want 0 40 1 1",
               sel_c, seg_c, dp_c, ready_c);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_total++;
      if (sel_a !== 2'((i / 4) % 4) || sel_c !== 2'(i % 4))
        $display("FAIL reset_step[%0d]: got sel_a=%0d sel_c=%0d want %0d %0d",
                 i, sel_a, sel_c, (i / 4) % 4, i % 4);
      else n_pass++;
      step(1);
    end
  endtask

  task automatic test_update();
    logic [6:0] exp_u [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    int k;
    offer(16'h12AF, 4'b0001);
    n_total++;
    if (ready_a !== 1'b0) $display("FAIL upd_ready_low: got %b want 0", ready_a);
    else n_pass++;
    wait_ready(40, k);
    n_total++;
    if (k >= 40) $display("FAIL upd_commit_timeout: waited %0d cycles want < 40", k);
    else n_pass++;
    for (int d = 0; d < 4; d++) begin
      n_total++;
      if (sel_a !== 2'(d) || seg_a !== exp_u[d] || dp_a !== (d != 0))
        $display("FAIL upd_digit[%0d]: got sel=%0d seg=%h dp=%b want %0d %h %b",
                 d, sel_a, seg_a, dp_a, d, exp_u[d], d != 0);
      else n_pass++;
      step(4);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    upd_data  = 16'h1234;
    upd_dp    = 4'b0000;
    upd_valid = 1'b1;
    @(negedge clk);
    upd_data = 16'h5555;
    upd_dp   = 4'b1010;
    n_total++;
    if (ready_a !== 1'b0) $display("FAIL b2b_blocked: got ready=%b want 0", ready_a);
    else n_pass++;
    wait_ready(40, k);
    n_total++;
    if (k >= 40 || seg_a !== 7'h19 || dp_a !== 1'b1)
      $display("FAIL b2b_first: got wait=%0d seg=%h dp=%b want <40 19 1", k, seg_a, dp_a);
    else n_pass++;
    @(negedge clk);
    upd_valid = 1'b0;
    n_total++;
    if (ready_a !== 1'b0) $display("FAIL b2b_second_accept: got ready=%b want 0", ready_a);
    else n_pass++;
    wait_ready(40, k);
    n_total++;
    if (k >= 40 || seg_a !== 7'h12 || dp_a !== 1'b1)
      $display("FAIL b2b_second_d0: got wait=%0d seg=%h dp=%b want <40 12 1", k, seg_a, dp_a);
    else n_pass++;
    step(4);
    n_total++;
    if (sel_a !== 2'd1 || seg_a !== 7'h12 || dp_a !== 1'b0)
      $display("FAIL b2b_second_d1: got sel=%0d seg=%h dp=%b want 1 12 0", sel_a, seg_a, dp_a);
    else n_pass++;
    step(12);
  endtask

  task automatic test_blank();
    logic [15:0] vals [2] = '{16'h0007, 16'h0000};
    logic [6:0]  exp_a [2][4] = '{'{7'h78, 7'h7F, 7'h7F, 7'h7F}, '{7'h40, 7'h7F, 7'h7F, 7'h7F}};
    logic [6:0]  exp_b [2][4] = '{'{7'h78, 7'h40, 7'h40, 7'h40}, '{7'h40, 7'h40, 7'h40, 7'h40}};
    int k;
    for (int c = 0; c < 2; c++) begin
      offer(vals[c], 4'b1000);
      wait_ready(40, k);
      for (int d = 0; d < 4; d++) begin
        n_total++;
        if (seg_a !== exp_a[c][d] || seg_b !== exp_b[c][d] || dp_a !== (d != 3))
          $display("FAIL blank[%h][%0d]: got a=%h b=%h dp=%b want %h %h %b",
                   vals[c], d, seg_a, seg_b, dp_a, exp_a[c][d], exp_b[c][d], d != 3);
        else n_pass++;
        step(4);
      end
    end
  endtask

  task automatic test_coincidence();
    int k = 0;
    while ((m_t % 16) != 15 && k < 20) begin
      @(negedge clk);
      k++;
    end
    offer(16'hBEEF, 4'b0000);
    n_total++;
    if (ready_a !== 1'b0) $display("FAIL coinc_accept: got ready=%b want 0", ready_a);
    else n_pass++;
    wait_ready(40, k);
    n_total++;
    if (k !== 16 || sel_a !== 2'd0 || seg_a !== 7'h0E)
      $display("FAIL coinc_commit: got wait=%0d sel=%0d seg=%h want 16 0 0E", k, sel_a, seg_a);
    else n_pass++;
  endtask

  task automatic test_random();
    int d;
    logic [15:0] r;
    for (int i = 0; i < 400; i++) begin
      d = (m_t / 4) % 4;
      n_total++;
      if ({sel_a, seg_a, dp_a, ready_a} !==
          {2'(d), exp_seg(m_disp, d, 1'b1), ~m_ddp[d], ~m_full} ||
          {sel_b, seg_b, dp_b, ready_b} !==
          {2'(d), exp_seg(m_disp, d, 1'b0), ~m_ddp[d], ~m_full} ||
          sel_c !== 2'(m_t % 4))
        $display("FAIL random[%0d]: got a=%0d/%h/%b/%b b=%h c=%0d want %0d/%h/%b/%b b=%h c=%0d",
                 i, sel_a, seg_a, dp_a, ready_a, seg_b, sel_c, d, exp_seg(m_disp, d, 1'b1),
                 ~m_ddp[d], ~m_full, exp_seg(m_disp, d, 1'b0), m_t % 4);
      else n_pass++;
      upd_valid = ($urandom_range(0, 3) == 0);
      if (!m_full) begin
        r = 16'($urandom);
        upd_data = r >> (4 * $urandom_range(0, 4));
        upd_dp   = 4'($urandom);
      end
      step(1);
    end
    upd_valid = 1'b0;
  endtask

  task automatic test_div1();
    int k = 0;
    step(6);
    offer(16'hC0DE, 4'b0100);
    n_total++;
    if (ready_c !== 1'b0) $display("FAIL div1_accept: got ready=%b want 0", ready_c);
    else n_pass++;
    while (!ready_c && k < 8) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (k < 1 || k > 4) $display("FAIL div1_latency: got %0d cycles want 1..4", k);
    else n_pass++;
    n_total++;
    if ({sel_c, seg_c, dp_c} !== {2'd0, 7'h06, 1'b1})
      $display("FAIL div1_d0: got sel=%0d seg=%h dp=%b want 0 06 1", sel_c, seg_c, dp_c);
    else n_pass++;
    step(1);
    n_total++;
    if ({sel_c, seg_c, dp_c} !== {2'd1, 7'h21, 1'b1})
      $display("FAIL div1_d1: got sel=%0d seg=%h dp=%b want 1 21 1", sel_c, seg_c, dp_c);
    else n_pass++;
    step(1);
    n_total++;
    if ({sel_c, seg_c, dp_c} !== {2'd2, 7'h40, 1'b0})
      $display("FAIL div1_d2: got sel=%0d seg=%h dp=%b want 2 40 0", sel_c, seg_c, dp_c);
    else n_pass++;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step(1);
    test_reset();
    test_update();
    test_back_to_back();
    test_blank();
    test_coincidence();
    test_random();
    test_div1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed scanner for a 4-digit seven-segment display.
- Holds a 16-bit hex value, steps a 2-bit digit index at a divided rate, and produces active-low segment and decimal-point codes for the selected digit.
- The digit index feeds the downstream 2-to-4 digit decoder, which generates the per-digit enables.
- New values arrive over a valid/ready handshake and are committed only at frame boundaries, so the display never shows a mix of old and new digits.

Parameters:
- DIV, 100000, clock cycles per digit slot; must be >= 1. At 100 MHz this gives 1 kHz per digit, 250 Hz per frame.
- BLANK_LZ, 1, when 1, leading zero digits are blanked. Digit 0 is never blanked.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- upd_valid  in  1  new value offered
- upd_data  in  16  value; nibble i is shown on digit i
- upd_dp  in  4  decimal point per digit, 1 = lit
- upd_ready  out  1  high when the pending slot is free
- digit_sel  out  2  current digit index, to the 2-to-4 digit decoder
- seg_n  out  7  active-low segments {g,f,e,d,c,b,a}
- dp_n  out  1  active-low decimal point for the current digit

Behaviour:
- Prescaler: cnt counts 0..DIV-1 and wraps to 0. tick = (cnt == DIV-1). With DIV = 1, tick is high every cycle.
- Digit counter: on tick, digit_sel <= digit_sel + 1, wrapping 3 -> 0.
- Frame boundary: tick && digit_sel == 3.
- Pending slot: registers pend_data[15:0], pend_dp[3:0], pend_full.
  - upd_ready = !pend_full.
  - When upd_valid && upd_ready: capture upd_data and upd_dp, set pend_full.
  - While pend_full, upd_valid is ignored, and the producer must hold its value.
- Commit: at a frame boundary with pend_full = 1:
  - disp_data <= pend_data, disp_dp <= pend_dp, pend_full <= 0.
  - The new value is shown from the next cycle, when digit_sel = 0.
- Simultaneous events:
  - Accept and frame boundary in the same cycle, with pend_full = 0: the value is captured, and the commit waits for the next frame boundary.
  - Commit at a frame boundary: upd_ready rises the following cycle.
- Segment output:
  - seg_n is a combinational function of the registered disp_data, disp_dp and digit_sel; there is no extra latency.
  - It changes in the same cycle as digit_sel.
- Hex encoding of seg_n, hex values:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30
  - 4 = 19, 5 = 12, 6 = 02, 7 = 78
  - 8 = 00, 9 = 10, A = 08, b = 03
  - C = 46, d = 21, E = 06, F = 0E
- Blanking (BLANK_LZ = 1): digit i, for i in 3..1, is blanked when nibbles 3 down to i are all zero. A blanked digit gives seg_n = 7F. dp_n is still driven by disp_dp[i].
- dp_n = ~disp_dp[digit_sel].
- Reset values: cnt = 0, digit_sel = 0, disp_data = 0, disp_dp = 0, pend_full = 0.
  - Resulting outputs: upd_ready = 1, seg_n = 40, dp_n = 1.
- Reset mid-operation: any pending or displayed value is discarded. The counters restart from 0 immediately, since reset is asynchronous.

Decomposition:
- Package seg_pkg:
  - typedef digit_idx_t (logic [1:0])
  - constant SEG_BLANK = 7'h7F
  - 16-entry hex-to-segment constant table
- Sub-module hex_to_seg: combinational 4-bit nibble to 7-bit active-low code. One instance, on the muxed nibble.
- The blanking mask and nibble mux stay in seg_scan_driver.

Test Plan (DIV = 4 unless stated):
- Reset release: rst pulse asynchronously mid-cycle -> immediately digit_sel = 0, seg_n = 40, dp_n = 1, upd_ready = 1. digit_sel steps 0,1,2,3,0 every 4 cycles.
- Update handshake: upd_valid with upd_data = 16'h12AF, upd_dp = 4'b0001 -> upd_ready = 0 until the frame boundary. Then digits 0..3 give seg_n = 0E, 08, 24, 79, and dp_n = 0 only on digit 0.
- Back-pressure: a second offer (16'h5555) while pend_full -> not accepted, display unchanged. It is accepted in the cycle after upd_ready rises.
- Leading-zero blank: 16'h0007 with BLANK_LZ = 1 -> digit 0 gives 78; digits 1-3 give 7F. Value 0 -> digit 0 gives 40, others 7F. With BLANK_LZ = 0, 16'h0007 -> digits 1-3 give 40.
- Boundary coincidence: accept in the same cycle as the frame boundary -> the display changes only at the following boundary, 16 cycles later.
- DIV = 1: digit_sel increments every cycle; commit occurs within 4 cycles of accept.
